// File: rtl/wb_pkg.sv
// Shared types for the writeback select stage: source select encoding and
// the skid register's occupancy states.
package wb_pkg;

  localparam int WB_SEL_W = 2;

  typedef enum logic [WB_SEL_W-1:0] {
    SEL_ALU    = 2'b00,
    SEL_IMM_ZX = 2'b01,
    SEL_IMM_SX = 2'b10,
    SEL_MEM    = 2'b11
  } wb_sel_e;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

endpackage

// File: rtl/wb_skid_reg.sv
// Registered valid/ready stage with a 2-entry skid (main + skid register).
// The outputs always come from the main register.
module wb_skid_reg
  import wb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload,
  output logic [1:0]   state
);

  // Handshake: a beat moves on a side only when that side's valid and ready are
  // both high at a rising edge; a producer holds its payload until that edge.
  // in_ready depends only on registered state, never on out_ready.
  logic         in_ready;
  logic         in_fire;
  logic         out_fire;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  assign in_ready    = (state != ST_FULL) & ~rst;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign out_valid   = (state != ST_EMPTY);
  assign out_payload = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q <= in_payload;
            state  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_fire && in_fire) begin
            main_q <= in_payload;
          end else if (out_fire) begin
            state  <= ST_EMPTY;
          end else if (in_fire) begin
            skid_q <= in_payload;
            state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// SIMD writeback select: picks ALU, extended immediate or memory data per lane
// and registers it with the destination address behind a skid handshake.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 12,
  parameter int LANES  = 4,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WB_SEL_W-1:0]       in_sel,
  input  logic [LANES*DATA_W-1:0]   in_alu,
  input  logic [LANES*DATA_W-1:0]   in_mem,
  input  logic [IMM_W-1:0]          in_imm,
  input  logic [ADDR_W-1:0]         in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]         out_addr
);

  localparam int PW = ADDR_W + LANES*DATA_W;

  wb_sel_e                   sel;
  logic [DATA_W-1:0]         imm_zx;
  logic [DATA_W-1:0]         imm_sx;
  logic [LANES*DATA_W-1:0]   sel_data;
  logic [PW-1:0]             out_payload;
  logic [1:0]                skid_state;

  assign sel = wb_sel_e'(in_sel);

  generate
    if (IMM_W == DATA_W) begin : g_imm_full
      assign imm_zx = in_imm;
      assign imm_sx = in_imm;
    end else begin : g_imm_ext
      assign imm_zx = {{(DATA_W-IMM_W){1'b0}}, in_imm};
      assign imm_sx = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    case (sel)
      SEL_ALU:    sel_data = in_alu;
      SEL_IMM_ZX: sel_data = {LANES{imm_zx}};
      SEL_IMM_SX: sel_data = {LANES{imm_sx}};
      SEL_MEM:    sel_data = in_mem;
      default:    sel_data = '0;
    endcase
  end

  wb_skid_reg #(.W(PW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_payload  ({in_addr, sel_data}),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload),
    .state       (skid_state)
  );

  // Same registered-only ready the skid register uses for its input fire.
  assign in_ready = (skid_state != ST_FULL) & ~rst;
  assign out_data = out_payload[LANES*DATA_W-1:0];
  assign out_addr = out_payload[PW-1:LANES*DATA_W];

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed vectors with literal expectations plus a
// queue model of accepted beats compared against the outputs every cycle.
module tb_wb_select_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_sel = 2'b00;
  logic [63:0] in_alu = '0;
  logic [63:0] in_mem = '0;
  logic [11:0] in_imm = '0;
  logic [3:0]  in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_addr;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  bit chk_en = 1'b0;
  logic [67:0] exp_q[$];

  wb_select_stage #(.DATA_W(16), .IMM_W(12), .LANES(4), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_alu    (in_alu),
    .in_mem    (in_mem),
    .in_imm    (in_imm),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Writeback value from the select rules, computed lane-wise with arithmetic.
  function automatic logic [63:0] model_data(input logic [1:0] s, input logic [63:0] alu,
                                             input logic [63:0] mem, input logic [11:0] imm);
    logic [15:0] lane;
    lane = 16'h0000;
    case (s)
      2'b00: return alu;
      2'b11: return mem;
      2'b01: lane = 16'(imm);
      default: lane = (imm >= 12'd2048) ? 16'(imm) + 16'hF000 : 16'(imm);
    endcase
    return {lane, lane, lane, lane};
  endfunction

  // driver: present a beat and hold it until accepted; returns just after the accepting edge
  task automatic send(input logic [1:0] s, input logic [63:0] alu, input logic [63:0] mem,
                      input logic [11:0] imm, input logic [3:0] a);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_sel = s; in_alu = alu; in_mem = mem; in_imm = imm; in_addr = a;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_timeout actual=%0d expected=accepted", n);
    end
  endtask

  // scoreboard / compare process
  initial begin
    bit s_rst, s_in_fire, s_out_fire, stall_prev, rst_prev;
    logic [67:0] new_beat, prev_out;
    stall_prev = 1'b0;
    rst_prev = 1'b1;
    prev_out = '0;
    wait (chk_en);
    forever begin
      @(negedge clk);
      check("out_valid", 68'(out_valid), 68'(exp_q.size() > 0));
      check("in_ready", 68'(in_ready), 68'(!rst && exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        check("out_data", 68'(out_data), 68'(exp_q[0][63:0]));
        check("out_addr", 68'(out_addr), 68'(exp_q[0][67:64]));
      end
      if (stall_prev && !rst_prev)
        check("stall_stable", {out_addr, out_data}, prev_out);
      if (exp_q.size() == 2)
        check("fire_in_full", 68'(in_valid & in_ready), 68'(0));
      s_rst = rst;
      s_in_fire = in_valid && in_ready;
      s_out_fire = out_valid && out_ready;
      new_beat = {in_addr, model_data(in_sel, in_alu, in_mem, in_imm)};
      stall_prev = out_valid && !out_ready;
      rst_prev = rst;
      prev_out = {out_addr, out_data};
      @(posedge clk);
      if (s_rst) exp_q.delete();
      else begin
        if (s_out_fire && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (s_in_fire) exp_q.push_back(new_beat);
      end
    end
  end

  initial begin
    int base;
    int n;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 68'(out_valid), 68'(0));
    check("rst_out_data", 68'(out_data), 68'(0));
    check("rst_out_addr", 68'(out_addr), 68'(0));
    check("rst_in_ready", 68'(in_ready), 68'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 68'(in_ready), 68'(1));
    @(posedge clk);
    #1;

    // 1: ALU pass-through
    out_ready = 1'b1;
    send(SEL_ALU, 64'h4444_3333_2222_1111, 64'h0, 12'h0, 4'd5);
    @(negedge clk);
    check("alu_valid", 68'(out_valid), 68'(1));
    check("alu_data", 68'(out_data), 68'(64'h4444_3333_2222_1111));
    check("alu_addr", 68'(out_addr), 68'(5));
    @(posedge clk);
    #1;

    // 2: immediate extension
    send(SEL_IMM_ZX, 64'h1234_5678_9ABC_DEF0, 64'h0, 12'hABC, 4'd3);
    @(negedge clk);
    check("imm_zx", 68'(out_data), 68'(64'h0ABC_0ABC_0ABC_0ABC));
    @(posedge clk);
    #1;
    send(SEL_IMM_SX, 64'h0, 64'h0, 12'hABC, 4'd4);
    @(negedge clk);
    check("imm_sx_neg", 68'(out_data), 68'(64'hFABC_FABC_FABC_FABC));
    @(posedge clk);
    #1;
    send(SEL_IMM_SX, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 12'h7FF, 4'd6);
    @(negedge clk);
    check("imm_sx_pos", 68'(out_data), 68'(64'h07FF_07FF_07FF_07FF));
    @(posedge clk);
    #1;

    // 3: memory select, ALU ignored
    send(SEL_MEM, 64'h5555_AAAA_5555_AAAA, 64'hFFFF_0001_BEEF_DEAD, 12'hFFF, 4'd9);
    @(negedge clk);
    check("mem_data", 68'(out_data), 68'(64'hFFFF_0001_BEEF_DEAD));
    check("mem_addr", 68'(out_addr), 68'(9));
    @(posedge clk);
    #1;

    // 4: stall then release
    out_ready = 1'b0;
    send(SEL_ALU, 64'hA0A0_A0A0_A0A0_A0A0, 64'h0, 12'h0, 4'd1);
    send(SEL_ALU, 64'hB0B0_B0B0_B0B0_B0B0, 64'h0, 12'h0, 4'd2);
    repeat (2) begin
      @(negedge clk);
      check("full_in_ready", 68'(in_ready), 68'(0));
      check("full_hold_a", {out_addr, out_data}, {4'd1, 64'hA0A0_A0A0_A0A0_A0A0});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_a", 68'(out_addr), 68'(1));
    @(negedge clk);
    check("drain_b", {out_addr, out_data}, {4'd2, 64'hB0B0_B0B0_B0B0_B0B0});
    check("ready_back", 68'(in_ready), 68'(1));
    @(negedge clk);
    check("drained", 68'(out_valid), 68'(0));
    @(posedge clk);
    #1;

    // 5: reset while full
    out_ready = 1'b0;
    send(SEL_ALU, 64'hCCCC_CCCC_CCCC_CCCC, 64'h0, 12'h0, 4'd7);
    send(SEL_ALU, 64'hDDDD_DDDD_DDDD_DDDD, 64'h0, 12'h0, 4'd8);
    rst = 1'b1;
    @(negedge clk);
    check("rst_full_ready", 68'(in_ready), 68'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 68'(out_valid), 68'(0));
    check("post_rst_data", 68'(out_data), 68'(0));
    check("post_rst_addr", 68'(out_addr), 68'(0));
    check("post_rst_ready", 68'(in_ready), 68'(1));
    repeat (3) begin
      @(negedge clk);
      check("no_ghost", 68'(out_valid), 68'(0));
    end
    @(posedge clk);
    #1;

    // 6: random traffic
    base = pops;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
               12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15)));
        end
      end
      begin
        n = 0;
        while (pops - base < 200 && n < 5000) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          n++;
        end
      end
    join
    check("rand_count", 68'(pops - base), 68'(200));
    check("rand_queue_empty", 68'(exp_q.size()), 68'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
